// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the CPU load/store port and the loader port.
// One access per cycle, round-robin with a bounded burst, read data routed back to its issuer.
//
// state    | meaning
// OWN_NONE | no grant last cycle; a tie goes to the CPU
// OWN_CPU  | CPU held the last grant; burst_cnt counts its consecutive grants
// OWN_LDR  | loader held the last grant; burst_cnt counts its consecutive grants
module dmem_arbiter #(
  parameter int AW        = 10,
  parameter int DW        = 32,
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_gnt,
  output logic          c_rvalid,
  output logic [DW-1:0] c_rdata,
  input  logic          l_req,
  input  logic          l_we,
  input  logic [AW-1:0] l_addr,
  input  logic [DW-1:0] l_wdata,
  output logic          l_gnt,
  output logic          l_rvalid,
  output logic [DW-1:0] l_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_LDR} owner_t;

  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] BURST_MAX = CW'(MAX_BURST);

  owner_t        owner, owner_nxt;
  logic [CW-1:0] burst_cnt, burst_cnt_nxt;
  logic          rd_pend, rd_pend_nxt;
  logic          rd_port, rd_port_nxt;  // 0 = CPU, 1 = loader

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner     <= OWN_NONE;
      burst_cnt <= '0;
      rd_pend   <= 1'b0;
      rd_port   <= 1'b0;
    end else begin
      owner     <= owner_nxt;
      burst_cnt <= burst_cnt_nxt;
      rd_pend   <= rd_pend_nxt;
      rd_port   <= rd_port_nxt;
    end
  end

  always_comb begin
    c_gnt         = 1'b0;
    l_gnt         = 1'b0;
    owner_nxt     = OWN_NONE;
    burst_cnt_nxt = '0;
    rd_pend_nxt   = 1'b0;
    rd_port_nxt   = rd_port;

    // Grants are forced off while reset is held, even though they are combinational.
    if (!rst) begin
      if (c_req && !l_req) begin
        c_gnt = 1'b1;
      end else if (l_req && !c_req) begin
        l_gnt = 1'b1;
      end else if (c_req && l_req) begin
        case (owner)
          OWN_CPU: begin
            c_gnt = (burst_cnt < BURST_MAX);
            l_gnt = !(burst_cnt < BURST_MAX);
          end
          OWN_LDR: begin
            l_gnt = (burst_cnt < BURST_MAX);
            c_gnt = !(burst_cnt < BURST_MAX);
          end
          default: c_gnt = 1'b1;
        endcase
      end
    end

    if (c_gnt) begin
      owner_nxt = OWN_CPU;
      if (owner == OWN_CPU)
        burst_cnt_nxt = (burst_cnt == BURST_MAX) ? burst_cnt : burst_cnt + CW'(1);
      else
        burst_cnt_nxt = CW'(1);
      rd_pend_nxt = !c_we;
      rd_port_nxt = 1'b0;
    end else if (l_gnt) begin
      owner_nxt = OWN_LDR;
      if (owner == OWN_LDR)
        burst_cnt_nxt = (burst_cnt == BURST_MAX) ? burst_cnt : burst_cnt + CW'(1);
      else
        burst_cnt_nxt = CW'(1);
      rd_pend_nxt = !l_we;
      rd_port_nxt = 1'b1;
    end
  end

  always_comb begin
    mem_en    = c_gnt | l_gnt;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (c_gnt) begin
      mem_we    = c_we;
      mem_addr  = c_addr;
      mem_wdata = c_wdata;
    end else if (l_gnt) begin
      mem_we    = l_we;
      mem_addr  = l_addr;
      mem_wdata = l_wdata;
    end
  end

  assign c_rvalid = rd_pend & ~rd_port;
  assign l_rvalid = rd_pend & rd_port;
  assign c_rdata  = c_rvalid ? mem_rdata : '0;
  assign l_rdata  = l_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a one-cycle-latency memory model.
module tb_dmem_arbiter;
  localparam int AW = 10;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          c_req, c_we, l_req, l_we;
  logic [AW-1:0] c_addr, l_addr;
  logic [DW-1:0] c_wdata, l_wdata;
  logic          c_gnt, c_rvalid, l_gnt, l_rvalid;
  logic [DW-1:0] c_rdata, l_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic [DW-1:0] mem [0:(1<<AW)-1];

  int checks = 0;
  int failures = 0;

  dmem_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(4)) dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge, where inputs are driven.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    c_req = 0; c_we = 0; c_addr = '0; c_wdata = '0;
    l_req = 0; l_we = 0; l_addr = '0; l_wdata = '0;
  endtask

  task automatic lwrite(input logic [AW-1:0] a, input logic [DW-1:0] d);
    idle();
    l_req = 1; l_we = 1; l_addr = a; l_wdata = d;
    #3 chk("preload_lgnt", l_gnt, 1);
    cyc();
  endtask

  logic exp_c [0:11] = '{1,1,1,1,0,0,0,0,1,1,1,1};

  initial begin
    rst = 1;
    idle();
    c_req = 1; c_addr = 10'h3ff;
    #3;
    chk("rst_cgnt", c_gnt, 0);
    chk("rst_memen", mem_en, 0);
    chk("rst_memaddr", mem_addr, 0);
    cyc();
    idle();
    rst = 0;

    lwrite(10'h00A, 32'h12345678);
    lwrite(10'h001, 32'h11);
    lwrite(10'h002, 32'h22);
    idle();
    cyc();

    // single CPU read
    c_req = 1; c_addr = 10'h00A;
    #3;
    chk("rd_cgnt", c_gnt, 1);
    chk("rd_lgnt", l_gnt, 0);
    chk("rd_memaddr", mem_addr, 10'h00A);
    chk("rd_memwe", mem_we, 0);
    cyc();
    idle();
    #3;
    chk("rd_crvalid", c_rvalid, 1);
    chk("rd_crdata", c_rdata, 32'h12345678);
    chk("rd_lrvalid", l_rvalid, 0);
    cyc();

    // tie from idle, both held
    c_req = 1; c_we = 1; c_addr = 10'h010; c_wdata = 32'hC0;
    l_req = 1; l_we = 1; l_addr = 10'h020; l_wdata = 32'hA0;
    for (int i = 0; i < 12; i++) begin
      #3;
      chk($sformatf("tie_cgnt%0d", i), c_gnt, exp_c[i]);
      chk($sformatf("tie_lgnt%0d", i), l_gnt, !exp_c[i]);
      cyc();
    end
    idle();
    cyc();

    // saturated lone loader, then CPU cuts in
    for (int i = 0; i < 10; i++) begin
      l_req = 1; l_we = 1; l_addr = 10'h100 + 10'(i); l_wdata = 32'(i);
      #3 chk($sformatf("lone_lgnt%0d", i), l_gnt, 1);
      cyc();
    end
    c_req = 1; c_we = 1; c_addr = 10'h030; c_wdata = 32'h5;
    #3;
    chk("sat_cgnt", c_gnt, 1);
    chk("sat_lgnt", l_gnt, 0);
    chk("sat_memaddr", mem_addr, 10'h030);
    cyc();
    c_req = 0;
    #3 chk("sat_lresume", l_gnt, 1);
    cyc();
    idle();
    cyc();

    // pipelined alternating reads
    c_req = 1; c_addr = 10'h001;
    #3 chk("pipe_cgnt", c_gnt, 1);
    cyc();
    idle();
    l_req = 1; l_addr = 10'h002;
    #3;
    chk("pipe_lgnt", l_gnt, 1);
    chk("pipe_c_rvalid1", c_rvalid, 1);
    chk("pipe_c_rdata1", c_rdata, 32'h11);
    chk("pipe_l_rvalid1", l_rvalid, 0);
    chk("pipe_l_rdata1", l_rdata, 0);
    cyc();
    idle();
    c_req = 1; c_addr = 10'h001;
    #3;
    chk("pipe_l_rvalid2", l_rvalid, 1);
    chk("pipe_l_rdata2", l_rdata, 32'h22);
    chk("pipe_c_rvalid2", c_rvalid, 0);
    chk("pipe_c_rdata2", c_rdata, 0);
    cyc();
    idle();
    #3;
    chk("pipe_c_rvalid3", c_rvalid, 1);
    chk("pipe_c_rdata3", c_rdata, 32'h11);
    chk("pipe_l_rvalid3", l_rvalid, 0);
    cyc();

    // loader write then CPU read of the same word
    l_req = 1; l_we = 1; l_addr = 10'h003; l_wdata = 32'hCAFE;
    #3;
    chk("wr_lgnt", l_gnt, 1);
    chk("wr_memwe", mem_we, 1);
    chk("wr_memwdata", mem_wdata, 32'hCAFE);
    cyc();
    idle();
    c_req = 1; c_addr = 10'h003;
    #3 chk("wr_cgnt", c_gnt, 1);
    cyc();
    idle();
    #3;
    chk("wr_crvalid", c_rvalid, 1);
    chk("wr_crdata", c_rdata, 32'hCAFE);
    cyc();

    // async reset with a read pending
    c_req = 1; c_addr = 10'h00A;
    #3 chk("rp_cgnt", c_gnt, 1);
    cyc();
    idle();
    l_req = 1; l_we = 1; l_addr = 10'h040;
    #1 chk("rp_pending", c_rvalid, 1);
    #1 rst = 1;
    #1;
    chk("ar_crvalid", c_rvalid, 0);
    chk("ar_lrvalid", l_rvalid, 0);
    chk("ar_crdata", c_rdata, 0);
    chk("ar_memen", mem_en, 0);
    chk("ar_cgnt", c_gnt, 0);
    chk("ar_lgnt", l_gnt, 0);
    chk("ar_memaddr", mem_addr, 0);
    cyc();
    #3;
    chk("ar_hold_crvalid", c_rvalid, 0);
    chk("ar_hold_lgnt", l_gnt, 0);
    cyc();
    rst = 0;
    c_req = 1; c_we = 1; c_addr = 10'h005; c_wdata = 32'hDEADBEEF;
    l_req = 1; l_we = 1; l_addr = 10'h006; l_wdata = 32'h1;
    #3;
    chk("post_cgnt", c_gnt, 1);
    chk("post_lgnt", l_gnt, 0);
    chk("post_memwe", mem_we, 1);
    chk("post_memaddr", mem_addr, 10'h005);
    chk("post_memwdata", mem_wdata, 32'hDEADBEEF);
    cyc();
    idle();
    #3;
    chk("post_crvalid", c_rvalid, 0);
    chk("post_lrvalid", l_rvalid, 0);
    chk("post_mem5", mem[5], 32'hDEADBEEF);
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single-port data memory between the CPU load/store port and the loader/debug port (bench-side or DMA preload of `in.dat`-style data). It issues at most one memory access per cycle, uses round-robin with a bounded burst allowance, and routes the one-cycle-latency read data back to the port that issued the read. It sits between `CPU`'s load/store path and `data_mem` inside the CPU top.

## Interface
- `AW`, 10, word-address width of data memory
- `DW`, 32, data width
- `MAX_BURST`, 4, max consecutive grants to one port while the other port is requesting (≥1)

- `clk`  in  1  clock, rising-edge
- `rst`  in  1  asynchronous, active-high reset
- `c_req`  in  1  CPU access request
- `c_we`  in  1  CPU write enable (1 = write, 0 = read)
- `c_addr`  in  AW  CPU word address
- `c_wdata`  in  DW  CPU write data
- `c_gnt`  out  1  CPU request accepted this cycle
- `c_rvalid`  out  1  CPU read data valid
- `c_rdata`  out  DW  CPU read data
- `l_req`, `l_we`, `l_addr`, `l_wdata`, `l_gnt`, `l_rvalid`, `l_rdata`  same directions/widths, loader port
- `mem_en`  out  1  memory access strobe
- `mem_we`  out  1  memory write enable
- `mem_addr`  out  AW  memory address
- `mem_wdata`  out  DW  memory write data
- `mem_rdata`  in  DW  memory read data, valid the cycle after a read strobe

## Operation
- State: `owner` ∈ {NONE, CPU, LDR}, `burst_cnt` (0..MAX_BURST, saturating), `rd_pend` (1 bit), `rd_port` (1 bit).
- Grant (combinational from `*_req` and state; at most one of `c_gnt`/`l_gnt` high):
  - only one port requesting → grant it.
  - both requesting, owner = NONE → CPU wins.
  - both requesting, owner = X, `burst_cnt` < MAX_BURST → grant X.
  - both requesting, `burst_cnt` = MAX_BURST → grant the other port.
- Memory command: `mem_en` = `c_gnt|l_gnt`; `mem_we`/`mem_addr`/`mem_wdata` muxed from the granted port; all zero when no grant.
- On clock edge with a grant to port P: if P = owner, `burst_cnt` += 1 (saturate at MAX_BURST); else owner ← P, `burst_cnt` ← 1.
- On clock edge with no grant: owner ← NONE, `burst_cnt` ← 0.
- Granted read (`we`=0): `rd_pend` ← 1, `rd_port` ← P; else `rd_pend` ← 0.
- Read return: `c_rvalid` = `rd_pend & rd_port==CPU`, `l_rvalid` likewise; `*_rdata` = `mem_rdata` when the matching `*_rvalid` is high, else 0.
- Writes produce no response beyond the grant.

## Timing
- Requester holds `req`, `we`, `addr`, `wdata` stable until it samples `gnt`=1; transfer occurs on that rising edge.
- Grant latency: 0 cycles when uncontested; back-to-back grants to the same port every cycle allowed.
- Read latency: `rvalid` exactly 1 cycle after the granting edge; reads can pipeline one per cycle.
- Contention: the other port waits at most MAX_BURST cycles.
- Lone requester: granted every cycle indefinitely; `burst_cnt` saturates at MAX_BURST, so a new competing request is granted on its first cycle.
- Reset (async, any time, incl. mid-burst or with a read pending): owner ← NONE, `burst_cnt` ← 0, `rd_pend` ← 0; all grants, `mem_en`, `mem_we`, `*_rvalid` = 0 and all data/address outputs = 0 while `rst` is high. A pending read return is dropped, never delivered after reset.
- First cycle after release: normal arbitration, CPU wins a tie.

## Test plan
- Reset: assert `rst` mid-cycle with a read pending → `c_rvalid`, `l_rvalid`, `mem_en`, both grants 0 immediately; after release, a CPU write to 0x005 of 0xDEADBEEF gets `c_gnt`=1 and `mem_we`=1 the same cycle.
- Single CPU read: memory preloaded 0x00A=0x12345678, CPU reads 0x00A → `c_gnt` cycle T, `c_rvalid`=1 with `c_rdata`=0x12345678 at T+1, `l_rvalid`=0.
- Tie from idle: both ports request in the same cycle → CPU granted first; with both held continuously, grant pattern is CPU×4, LDR×4, CPU×4 (MAX_BURST=4).
- Saturated lone requester: loader streams 10 writes alone, CPU then requests → CPU granted on its first request cycle; loader resumes next.
- Pipelined mixed reads: CPU read 0x001, loader read 0x002 on alternating cycles (values 0x11, 0x22) → each `rvalid` fires only on its own port one cycle later with the correct data; no cross-routing.
- Write/read ordering: loader writes 0x003=0xCAFE, CPU reads 0x003 in the next granted cycle → `c_rdata`=0xCAFE.
